// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_enable = 4'b0001 << lo;
      SZ_HALF: lane_enable = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_enable = 4'b1111;
      default: lane_enable = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM with per-byte-lane write enables and combinational read.
module dmem_bank #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte/half/word access with a single-cycle response pulse.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, sgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, wdata_rep, bank_rdata;
  logic        rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_rdata_d;
  logic        capture, access, req_err, in_range;
  logic [3:0]  bank_we;

  assign in_range = (addr_q >> (ADDR_W + 2)) == 32'd0;
  assign req_err  = (size_q == 2'b11) || ((size_q == SZ_HALF) && addr_q[0]) ||
                    ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00)) || !in_range;

  always_comb begin
    case (size_q)
      SZ_BYTE: wdata_rep = {4{wdata_q[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata_q[15:0]}};
      default: wdata_rep = wdata_q;
    endcase
  end

  // Reset wins over an access that lands on the same edge.
  assign bank_we = lane_enable(size_q, addr_q[1:0]) & {4{access & we_q & ~reset}};

  dmem_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .addr (addr_q[ADDR_W+1:2]),
    .wdata(wdata_rep),
    .rdata(bank_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    access      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        // Faulty requests skip the countdown and never touch the RAM.
        if (req_err) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (cnt_q == 4'd0) begin
          access      = 1'b1;
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'd0 : load_extract(bank_rdata, size_q, addr_q[1:0], sgn_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= req_we;
      size_q  <= req_size;
      sgn_q   <= req_signed;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle);

endmodule
